// File: rtl/wb_dma_raw_reader.sv
`default_nettype none
// ============================================================================
// Module      : wb_dma_raw_reader
// Description : DMA-style reader for the raw port of the dual-port buffer RAM.
//               Accepts a {start, length} command, issues sequential word reads
//               on the raw port and emits the returned words as a valid/ready
//               stream, flagging the final word with m_last_o.
//
// Ports
//   rawp_clk / rawp_rst          clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_addr_i / cmd_len_i       start word address, length in words
//   rawp_adr_o                   raw-port word address
//   rawp_dat_o / rawp_we_o       raw-port write data / enable (always 0)
//   rawp_dat_i                   raw-port read data (one-cycle latency)
//   rawp_stall_i                 raw-port stall (no read when high)
//   m_data_o / m_valid_o /
//   m_last_o / m_ready_i         output stream
//   busy_o                       transfer in progress
//   done_o                       one-cycle completion pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module wb_dma_raw_reader #(
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  rawp_clk,
    input  logic                  rawp_rst,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic [ADDR_WIDTH-1:0] rawp_adr_o,
    output logic [31:0]           rawp_dat_o,
    output logic                  rawp_we_o,
    input  logic [31:0]           rawp_dat_i,
    input  logic                  rawp_stall_i,
    output logic [31:0]           m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [2:0] c_FIFO_DEPTH = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_done_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remain;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_done;

    logic [32:0]           r_fifo [4];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_fifo_pop;

    // ------------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------------
    assign w_accept     = (r_state == ST_IDLE) && cmd_valid_i;
    assign w_fifo_empty = (r_count == 3'd0);

    // Credit check counts the read whose data returns this cycle, so the
    // buffered words plus the one on the bus can never exceed the FIFO depth.
    assign w_issue = (r_state == ST_READ) && !rawp_stall_i &&
                     (r_remain != '0) &&
                     ((r_count + {2'b00, r_inflight}) < c_FIFO_DEPTH);

    // Fall-through: with the FIFO empty the returning word is presented
    // directly and only written into storage if the consumer is not ready.
    assign m_valid_o = !w_fifo_empty || r_inflight;
    assign m_data_o  = w_fifo_empty ? rawp_dat_i      : r_fifo[r_rd_ptr][31:0];
    assign m_last_o  = w_fifo_empty ? r_inflight_last : r_fifo[r_rd_ptr][32];

    assign w_pop      = m_valid_o && m_ready_i;
    assign w_push     = r_inflight && !(w_fifo_empty && m_ready_i);
    assign w_fifo_pop = w_pop && !w_fifo_empty;

    assign cmd_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE) || r_done;
    assign done_o      = r_done;
    assign rawp_adr_o  = r_addr;
    assign rawp_dat_o  = 32'd0;
    assign rawp_we_o   = 1'b0;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge rawp_clk) begin
        if (rawp_rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_len_i == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (w_issue && (r_remain == LEN_WIDTH'(1))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && m_last_o) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Address / length counters and in-flight tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge rawp_clk) begin
        if (rawp_rst) begin
            r_addr          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= cmd_addr_i;
                r_remain <= cmd_len_i;
            end else if (w_issue) begin
                r_addr   <= r_addr + ADDR_WIDTH'(1);
                r_remain <= r_remain - LEN_WIDTH'(1);
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remain == LEN_WIDTH'(1));
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge rawp_clk) begin
        if (rawp_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_fifo_pop};
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge rawp_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {r_inflight_last, rawp_dat_i};
        end
    end

endmodule
`default_nettype wire
